spart_receiver: RTL and testbench
=================================

SPART_RECEIVER -- requirements
Module: spart_receiver

Interface
REQ-001 SHALL have parameter DATA_BITS, default 8, data bits per frame, legal 5..9.
REQ-002 SHALL have parameter OVERSAMPLE, default 16, baud ticks per bit period, even, legal 8..32.
REQ-003 SHALL have parameter PARITY_EN, default 0, 1 = parity bit follows data.
REQ-004 SHALL have parameter PARITY_ODD, default 0, 1 = odd parity, 0 = even; ignored when PARITY_EN=0.
REQ-005 SHALL have parameter STOP_BITS, default 1, stop bits checked, legal 1..2.
REQ-006 SHALL have parameter FIFO_DEPTH, default 4, receive FIFO entries, power of 2, legal 2..16.
REQ-007 SHALL have port clk  input  1  system clock, all state on rising edge.
REQ-008 SHALL have port reset  input  1  asynchronous active-low reset.
REQ-009 SHALL have port RxD  input  1  asynchronous serial line, idle high.
REQ-010 SHALL have port baud_rate_generator  input  1  one-clk enable pulse at OVERSAMPLE x baud rate.
REQ-011 SHALL have port rd_en  input  1  pop FIFO head.
REQ-012 SHALL have port clr_err  input  1  clear sticky error flags.
REQ-013 SHALL have port receiver_buffer  output  DATA_BITS  FIFO head data, first-word fall-through.
REQ-014 SHALL have port RDA  output  1  FIFO not empty.
REQ-015 SHALL have port fifo_count  output  $clog2(FIFO_DEPTH)+1  entries held.
REQ-016 SHALL have port framing_err, parity_err, overrun  output  1 each  sticky error flags.

Function
REQ-017 SHALL pass RxD through a two-flop synchronizer; all sampling uses the synchronized value.
REQ-018 SHALL implement FSM IDLE, START, DATA, PARITY, STOP; tick counter and bit counter advance only on baud_rate_generator cycles.
REQ-019 IDLE -> START on synchronized RxD low; tick counter cleared.
REQ-020 START: after OVERSAMPLE/2 ticks sample line; low -> DATA; high -> IDLE (glitch rejected, no flag, no push).
REQ-021 DATA: sample every OVERSAMPLE ticks, LSB first, DATA_BITS samples, then PARITY if PARITY_EN else STOP.
REQ-022 PARITY: sample after OVERSAMPLE ticks; mismatch vs XOR of data (inverted when PARITY_ODD) marks frame bad-parity.
REQ-023 STOP: sample STOP_BITS times at OVERSAMPLE-tick spacing; any low sample marks frame bad-framing; after last sample -> IDLE immediately (mid stop bit).
REQ-024 Good frame SHALL be written to FIFO on the clock after the final stop sample; RDA and receiver_buffer valid one clk later.
REQ-025 Bad-parity or bad-framing frame SHALL NOT be written; corresponding sticky flag set.
REQ-026 Good frame arriving with FIFO full and rd_en low SHALL be dropped, overrun set, existing contents unchanged.
REQ-027 Push and rd_en same cycle: both performed; when full, pop frees the slot, no overrun.
REQ-028 rd_en with FIFO empty SHALL be ignored; count never underflows.
REQ-029 Pointers SHALL wrap modulo FIFO_DEPTH; fifo_count ranges 0..FIFO_DEPTH.
REQ-030 clr_err clears all three flags; simultaneous set event wins.
REQ-031 RxD low held through STOP (break) SHALL set framing_err once per frame, re-enter START only after line returns high then low.

Reset
REQ-032 reset low SHALL immediately force FSM IDLE, counters 0, FIFO empty, RDA 0, fifo_count 0, receiver_buffer 0, all error flags 0, synchronizer flops 1.
REQ-033 reset asserted mid-frame SHALL abort frame with no push and no flag; reception resumes at next start bit after release.

Verification
REQ-034 Default params, frame 0xA5 8N1 -> receiver_buffer 0xA5, RDA 1, fifo_count 1, no flags; rd_en pulse -> RDA 0.
REQ-035 Four frames 0x01,0x02,0x03,0x04 then fifth 0x05, no reads -> overrun 1, pops return 0x01..0x04 in order, then RDA 0.
REQ-036 RxD low pulse of OVERSAMPLE/4 ticks -> no push, no flags, FSM returns to IDLE.
REQ-037 PARITY_EN=1, PARITY_ODD=0, send 0x07 with parity bit 0 -> parity_err 1, fifo_count 0; clr_err -> 0.
REQ-038 STOP_BITS=2, second stop bit low -> framing_err 1, no push; DATA_BITS=5 frame 0x15 -> receiver_buffer 0x15.
REQ-039 reset low during bit 4 of frame -> all outputs zero; next full frame 0x3C received correctly.

Source files
------------

// File: rtl/spart_receiver.sv
// spart_receiver: oversampled async serial receiver with sticky error flags
// and a first-word fall-through receive FIFO.
module spart_receiver #(
  parameter int DATA_BITS  = 8,
  parameter int OVERSAMPLE = 16,
  parameter int PARITY_EN  = 0,
  parameter int PARITY_ODD = 0,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          RxD,
  input  logic                          baud_rate_generator,
  input  logic                          rd_en,
  input  logic                          clr_err,
  output logic [DATA_BITS-1:0]          receiver_buffer,
  output logic                          RDA,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          framing_err,
  output logic                          parity_err,
  output logic                          overrun
);

  localparam int TW = $clog2(OVERSAMPLE);
  localparam int BW = 4;
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam logic ODD = (PARITY_ODD != 0);

  typedef enum logic [2:0] {
    IDLE, START, DATA, PARITY, STOP
  } state_t;

  state_t               state_q, state_d;
  logic [1:0]           sync_q;
  logic                 rx_s;
  logic [TW-1:0]        tick_q, tick_d;
  logic [BW-1:0]        bit_q, bit_d;
  logic [DATA_BITS-1:0] sh_q, sh_d;
  logic                 pbad_q, pbad_d;
  logic                 fbad_q, fbad_d;
  logic                 armed_q, armed_d;
  logic                 done;
  logic                 last, half;
  logic                 push_q, perr_q, ferr_q;

  logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]        wr_ptr, rd_ptr;
  logic [CW-1:0]        count_q;
  logic                 full, empty, do_pop, do_push, drop;

  assign rx_s = sync_q[1];
  assign last = (tick_q == TW'(OVERSAMPLE - 1));
  assign half = (tick_q == TW'(OVERSAMPLE / 2 - 1));

  // Two-flop synchronizer for the asynchronous line, idles high.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) sync_q <= 2'b11;
    else        sync_q <= {sync_q[0], RxD};
  end

  // Receive FSM state and datapath registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      tick_q  <= '0;
      bit_q   <= '0;
      sh_q    <= '0;
      pbad_q  <= 1'b0;
      fbad_q  <= 1'b0;
      armed_q <= 1'b1;
      push_q  <= 1'b0;
      perr_q  <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      tick_q  <= tick_d;
      bit_q   <= bit_d;
      sh_q    <= sh_d;
      pbad_q  <= pbad_d;
      fbad_q  <= fbad_d;
      armed_q <= armed_d;
      push_q  <= done & ~pbad_q & ~fbad_d;
      perr_q  <= done & pbad_q;
      ferr_q  <= done & fbad_d;
    end
  end

  // Next-state logic; a frame ending on a low line (break) disarms the
  // start detector until the line has been seen high again.
  always_comb begin
    state_d = state_q;
    tick_d  = tick_q;
    bit_d   = bit_q;
    sh_d    = sh_q;
    pbad_d  = pbad_q;
    fbad_d  = fbad_q;
    armed_d = armed_q;
    done    = 1'b0;
    unique case (state_q)
      IDLE: begin
        tick_d = '0;
        bit_d  = '0;
        pbad_d = 1'b0;
        fbad_d = 1'b0;
        if (rx_s)         armed_d = 1'b1;
        else if (armed_q) state_d = START;
      end
      START: if (baud_rate_generator) begin
        if (half) begin
          tick_d  = '0;
          state_d = rx_s ? IDLE : DATA;
        end else begin
          tick_d = tick_q + 1'b1;
        end
      end
      DATA: if (baud_rate_generator) begin
        if (last) begin
          tick_d = '0;
          sh_d   = {rx_s, sh_q[DATA_BITS-1:1]};
          if (bit_q == BW'(DATA_BITS - 1)) begin
            bit_d   = '0;
            state_d = (PARITY_EN != 0) ? PARITY : STOP;
          end else begin
            bit_d = bit_q + 1'b1;
          end
        end else begin
          tick_d = tick_q + 1'b1;
        end
      end
      PARITY: if (baud_rate_generator) begin
        if (last) begin
          tick_d  = '0;
          pbad_d  = rx_s != ((^sh_q) ^ ODD);
          state_d = STOP;
        end else begin
          tick_d = tick_q + 1'b1;
        end
      end
      STOP: if (baud_rate_generator) begin
        if (last) begin
          tick_d = '0;
          if (!rx_s) fbad_d = 1'b1;
          if (bit_q == BW'(STOP_BITS - 1)) begin
            bit_d   = '0;
            done    = 1'b1;
            state_d = IDLE;
            if (!rx_s) armed_d = 1'b0;
          end else begin
            bit_d = bit_q + 1'b1;
          end
        end else begin
          tick_d = tick_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign full    = (count_q == CW'(FIFO_DEPTH));
  assign empty   = (count_q == '0);
  assign do_pop  = rd_en & ~empty;
  assign do_push = push_q & (~full | do_pop);
  assign drop    = push_q & full & ~do_pop;

  // FIFO storage; contents are only meaningful below fifo_count.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= sh_q;
  end

  // FIFO pointers and occupancy.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      if (do_push && !do_pop)      count_q <= count_q + 1'b1;
      else if (do_pop && !do_push) count_q <= count_q - 1'b1;
    end
  end

  // Sticky error flags; a set in the same cycle as clr_err wins.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      framing_err <= 1'b0;
      parity_err  <= 1'b0;
      overrun     <= 1'b0;
    end else begin
      framing_err <= ferr_q | (framing_err & ~clr_err);
      parity_err  <= perr_q | (parity_err & ~clr_err);
      overrun     <= drop | (overrun & ~clr_err);
    end
  end

  assign RDA             = ~empty;
  assign fifo_count      = count_q;
  assign receiver_buffer = empty ? '0 : mem[rd_ptr];

endmodule

// File: tb/tb_spart_receiver.sv
// tb_spart_receiver: directed frames into three receiver configurations,
// popped data checked against an expected-data scoreboard per instance.
module tb_spart_receiver;

  localparam int BIT = 64;

  logic       clk = 0;
  logic       rst_n = 0;
  logic [2:0] rxd = 3'b111;
  logic       baud = 0;
  logic [2:0] rd_en = 3'b000;
  logic [2:0] clr = 3'b000;

  logic [7:0] rb0, rb1;
  logic [4:0] rb2;
  logic [2:0] rda, fe, pe, ov;
  logic [2:0] cnt0, cnt1, cnt2;

  logic [8:0] q0[$], q1[$], q2[$];
  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  spart_receiver u0 (
    .clk(clk), .reset(rst_n), .RxD(rxd[0]),
    .baud_rate_generator(baud), .rd_en(rd_en[0]),
    .clr_err(clr[0]), .receiver_buffer(rb0),
    .RDA(rda[0]), .fifo_count(cnt0),
    .framing_err(fe[0]), .parity_err(pe[0]),
    .overrun(ov[0])
  );

  spart_receiver #(.PARITY_EN(1), .PARITY_ODD(0)) u1 (
    .clk(clk), .reset(rst_n), .RxD(rxd[1]),
    .baud_rate_generator(baud), .rd_en(rd_en[1]),
    .clr_err(clr[1]), .receiver_buffer(rb1),
    .RDA(rda[1]), .fifo_count(cnt1),
    .framing_err(fe[1]), .parity_err(pe[1]),
    .overrun(ov[1])
  );

  spart_receiver #(.DATA_BITS(5), .STOP_BITS(2)) u2 (
    .clk(clk), .reset(rst_n), .RxD(rxd[2]),
    .baud_rate_generator(baud), .rd_en(rd_en[2]),
    .clr_err(clr[2]), .receiver_buffer(rb2),
    .RDA(rda[2]), .fifo_count(cnt2),
    .framing_err(fe[2]), .parity_err(pe[2]),
    .overrun(ov[2])
  );

  initial begin
    forever begin
      repeat (3) @(posedge clk);
      #1 baud = 1;
      @(posedge clk);
      #1 baud = 0;
    end
  end

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic sb(input string nm, input logic [8:0] act,
                    inout logic [8:0] q[$]);
    logic [8:0] e;
    n_chk++;
    if (q.size() == 0) begin
      n_fail++;
      $display("FAIL %s: popped %0h with nothing expected", nm, act);
    end else begin
      e = q.pop_front();
      if (act !== e) begin
        n_fail++;
        $display("FAIL %s: got %0h expected %0h", nm, act, e);
      end
    end
  endtask

  always @(negedge clk) begin
    if (rd_en[0] && rda[0]) sb("sb0", {1'b0, rb0}, q0);
    if (rd_en[1] && rda[1]) sb("sb1", {1'b0, rb1}, q1);
    if (rd_en[2] && rda[2]) sb("sb2", {4'b0, rb2}, q2);
  end

  task automatic send(input int w, input logic [15:0] v, input int n);
    @(posedge clk);
    #1;
    for (int i = 0; i < n; i++) begin
      rxd[w] = v[i];
      repeat (BIT) @(posedge clk);
      #1;
    end
    rxd[w] = 1'b1;
    repeat (4) @(posedge clk);
  endtask

  task automatic pop(input int w);
    @(posedge clk);
    #1 rd_en[w] = 1'b1;
    @(posedge clk);
    #1 rd_en[w] = 1'b0;
    @(negedge clk);
  endtask

  task automatic clear(input int w);
    @(posedge clk);
    #1 clr[w] = 1'b1;
    @(posedge clk);
    #1 clr[w] = 1'b0;
    @(negedge clk);
  endtask

  task automatic f8(input logic [7:0] d, input bit exp_push);
    if (exp_push) q0.push_back({1'b0, d});
    send(0, {7'h7F, d, 1'b0}, 10);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_rda", rda, 0);
    chk("rst_cnt", {cnt0, cnt1, cnt2}, 0);
    chk("rst_flags", {fe, pe, ov}, 0);
    chk("rst_buf", {rb0, rb1, rb2}, 0);
    #1 rst_n = 1;
    repeat (10) @(posedge clk);

    f8(8'hA5, 1);
    @(negedge clk);
    chk("a5_buf", rb0, 8'hA5);
    chk("a5_rda", rda[0], 1);
    chk("a5_cnt", cnt0, 1);
    chk("a5_flags", {fe[0], pe[0], ov[0]}, 0);
    pop(0);
    chk("a5_rda_after_pop", rda[0], 0);

    for (int i = 1; i <= 4; i++) f8(8'(i), 1);
    f8(8'h05, 0);
    @(negedge clk);
    chk("ovr_flag", ov[0], 1);
    chk("ovr_cnt", cnt0, 4);
    chk("ovr_head", rb0, 8'h01);
    for (int i = 0; i < 4; i++) pop(0);
    chk("ovr_rda_empty", rda[0], 0);
    pop(0);
    chk("underflow_cnt", cnt0, 0);
    clear(0);
    chk("ovr_cleared", ov[0], 0);

    @(posedge clk);
    #1 rxd[0] = 1'b0;
    repeat (16) @(posedge clk);
    #1 rxd[0] = 1'b1;
    repeat (2 * BIT) @(negedge clk);
    chk("glitch_cnt", cnt0, 0);
    chk("glitch_flags", {fe[0], pe[0], ov[0]}, 0);
    f8(8'h5A, 1);
    pop(0);

    @(posedge clk);
    #1 rxd[0] = 1'b0;
    repeat (10 * BIT) @(posedge clk);
    @(negedge clk);
    chk("break_fe", fe[0], 1);
    chk("break_cnt", cnt0, 0);
    clear(0);
    repeat (3 * BIT) @(posedge clk);
    @(negedge clk);
    chk("break_fe_once", fe[0], 0);
    #1 rxd[0] = 1'b1;
    repeat (2 * BIT) @(posedge clk);
    f8(8'h33, 1);
    pop(0);

    send(1, {6'h3F, 1'b0, 8'h07, 1'b0}, 11);
    @(negedge clk);
    chk("par_err", pe[1], 1);
    chk("par_cnt", cnt1, 0);
    clear(1);
    chk("par_cleared", pe[1], 0);
    q1.push_back(9'h0C3);
    send(1, {6'h3F, 1'b0, 8'hC3, 1'b0}, 11);
    @(negedge clk);
    chk("par_good_flag", pe[1], 0);
    pop(1);

    send(2, {8'hFF, 1'b0, 1'b1, 5'h15, 1'b0}, 8);
    @(negedge clk);
    chk("stop2_fe", fe[2], 1);
    chk("stop2_cnt", cnt2, 0);
    clear(2);
    q2.push_back(9'h015);
    send(2, {8'hFF, 1'b1, 1'b1, 5'h15, 1'b0}, 8);
    @(negedge clk);
    chk("d5_buf", rb2, 5'h15);
    chk("d5_flags", fe[2], 0);
    pop(2);

    f8(8'h11, 0);
    @(negedge clk);
    chk("pre_rst_cnt", cnt0, 1);
    fork
      f8(8'hF7, 0);
      begin
        repeat (5 * BIT + 10) @(posedge clk);
        #1 rst_n = 0;
        @(negedge clk);
        chk("mid_rst_rda", rda[0], 0);
        chk("mid_rst_cnt", cnt0, 0);
        chk("mid_rst_buf", rb0, 0);
        chk("mid_rst_flags", {fe[0], pe[0], ov[0]}, 0);
        repeat (3) @(posedge clk);
        #1 rst_n = 1;
      end
    join
    @(negedge clk);
    chk("post_rst_cnt", cnt0, 0);
    chk("post_rst_flags", {fe[0], pe[0], ov[0]}, 0);
    f8(8'h3C, 1);
    @(negedge clk);
    chk("3c_buf", rb0, 8'h3C);
    pop(0);

    repeat (4) @(negedge clk);
    chk("sb0_drained", q0.size(), 0);
    chk("sb1_drained", q1.size(), 0);
    chk("sb2_drained", q2.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
